// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for the multicycle MIPS32 datapath. It decodes the opcode
// held in the instruction register, steps through fetch / decode / execute /
// memory / writeback (one state per clock) and drives the aluOp code consumed
// by alu_decoder, together with every datapath mux select and write enable.
//
// Build option:
//   MC_ADDI_EN  when defined, addi (opcode 001000) runs through ADDIEX and
//               ADDIWB. When undefined, addi decodes as an illegal opcode and
//               encodings 9/10 behave like the unused encodings 12-15.
//
// Parameters:
//   STATE_W     width of the debug state output (must be >= 4)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   opcode      instr[31:26] from the instruction register
//   zero        ALU zero flag, same cycle (only used for beq)
//   iorD        memory address select: 0 = PC, 1 = ALUOut
//   memWrite    data memory write enable
//   irWrite     instruction register load enable
//   regDst      destination register select: 0 = rt, 1 = rd
//   memtoReg    register writeback select: 0 = ALUOut, 1 = MDR
//   regWrite    register file write enable
//   aluSrcA     ALU A select: 0 = PC, 1 = A register
//   aluSrcB     ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   aluOp       to alu_decoder: 00 = add, 01 = sub, 10 = use funct
//   pcSrc       next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//   pcEn        PC load enable = pcWrite | (branch & zero)
//   illegalOp   one-cycle pulse: unsupported opcode seen in DECODE
//   state       current FSM state, for debug
//
// Timing notes:
//   All mux selects and enables come from a control register that is loaded
//   with the decode of the *next* state on the same edge that loads the state
//   register, so they stay a pure function of the current state while being
//   glitch-free register outputs. The only combinational paths are:
//     - pcEn       (needs the same-cycle ALU zero flag for beq)
//     - illegalOp  (needs the live opcode during DECODE)
//     - reset gating of memWrite, irWrite, regWrite, pcEn and illegalOp, so
//       that no storage element is written while reset is high, even when
//       reset arrives in the middle of an instruction.
// -----------------------------------------------------------------------------
module multicycle_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               iorD,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regDst,
  output logic               memtoReg,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSrc,
  output logic               pcEn,
  output logic               illegalOp,
  output logic [STATE_W-1:0] state
);

  // ---------------------------------------------------------------------------
  // Opcodes understood by this controller
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ---------------------------------------------------------------------------
  // State encoding (values are visible on the debug port, so they are fixed)
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  // Control word. pcWrite and branch never leave this module; they only
  // feed the pcEn term.
  typedef struct packed {
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       branch;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // Opcode legality. Anything not listed here sends DECODE back to FETCH and
  // raises illegalOp for that one DECODE cycle.
  // ---------------------------------------------------------------------------
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI:                              ok = 1'b1;
`endif
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // Moore output decode: every field defaults to 0, each state only lists the
  // fields it asserts. Unused encodings (and 9/10 without addi support) fall
  // into the default and produce an all-zero control word.
  // ---------------------------------------------------------------------------
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.aluSrcB = 2'b01;
        c.irWrite = 1'b1;
        c.pcWrite = 1'b1;
      end
      DECODE: begin
        c.aluSrcB = 2'b11;
      end
      MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      MEMRD: begin
        c.iorD = 1'b1;
      end
      MEMWB: begin
        c.memtoReg = 1'b1;
        c.regWrite = 1'b1;
      end
      MEMWR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      RTYPEEX: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b10;
      end
      RTYPEWB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      BEQEX: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b01;
        c.pcSrc   = 2'b01;
        c.branch  = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      ADDIWB: begin
        c.regWrite = 1'b1;
      end
`endif
      JEX: begin
        c.pcSrc   = 2'b10;
        c.pcWrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state decode. The opcode is consulted in DECODE and again in MEMADR
  // (lw vs sw); it is guaranteed stable everywhere outside FETCH.
  // ---------------------------------------------------------------------------
  function automatic state_t next_for(input state_t s, input logic [5:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = RTYPEEX;
          OP_BEQ:       n = BEQEX;
`ifdef MC_ADDI_EN
          OP_ADDI:      n = ADDIEX;
`endif
          OP_J:         n = JEX;
          default:      n = FETCH;
        endcase
      end
      MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = MEMWB;
      RTYPEEX: n = RTYPEWB;
`ifdef MC_ADDI_EN
      ADDIEX:  n = ADDIWB;
`endif
      // MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX and every unused encoding
      // retire to FETCH.
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered control word
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = next_for(state_q, opcode);
  end

  // The control register always holds ctrl_for(state_q): both are loaded from
  // the same next-state value on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic in_decode;
  assign in_decode = (state_q == DECODE);

  // Pure mux selects: straight from the control register.
  assign iorD     = ctrl_q.iorD;
  assign regDst   = ctrl_q.regDst;
  assign memtoReg = ctrl_q.memtoReg;
  assign aluSrcA  = ctrl_q.aluSrcA;
  assign aluSrcB  = ctrl_q.aluSrcB;
  assign aluOp    = ctrl_q.aluOp;
  assign pcSrc    = ctrl_q.pcSrc;

  // Storage write enables are killed combinationally during reset so a reset
  // that lands mid-instruction (for example in MEMWR) never commits a write.
  assign memWrite = ctrl_q.memWrite & ~reset;
  assign irWrite  = ctrl_q.irWrite  & ~reset;
  assign regWrite = ctrl_q.regWrite & ~reset;

  // beq only loads the PC when the comparison in this cycle came out equal.
  assign pcEn = (ctrl_q.pcWrite | (ctrl_q.branch & zero)) & ~reset;

  // Single-cycle pulse: DECODE always lasts exactly one cycle.
  assign illegalOp = in_decode & ~op_supported(opcode) & ~reset;

  // Debug view of the state, zero-extended to the requested width.
  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
//
// Self-checking bench for multicycle_main_control. For every cycle the driver
// predicts the full output vector from an independent reference model of the
// controller (state sequence per instruction plus the per-state output
// table), pushes it onto exp_q, and the vector seen on the DUT pins at the
// following falling edge is popped and compared.
//
// Compares against the MC_ADDI_EN build when that macro is defined, otherwise
// treats addi as an illegal opcode.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

  localparam int VW = 19;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic       pcEn, illegalOp;
  logic [3:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_main_control #(.STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .zero     (zero),
    .iorD     (iorD),
    .memWrite (memWrite),
    .irWrite  (irWrite),
    .regDst   (regDst),
    .memtoReg (memtoReg),
    .regWrite (regWrite),
    .aluSrcA  (aluSrcA),
    .aluSrcB  (aluSrcB),
    .aluOp    (aluOp),
    .pcSrc    (pcSrc),
    .pcEn     (pcEn),
    .illegalOp(illegalOp),
    .state    (state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] obs,
                          input logic [VW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {state, iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA,
            aluSrcB, aluOp, pcSrc, pcEn, illegalOp};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic addi_on();
`ifdef MC_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) ||
           ((op == 6'b001000) && addi_on());
  endfunction

  // Expected pin vector for a given state, zero flag, illegal flag and reset.
  function automatic logic [VW-1:0] exp_vec(input logic [3:0] st, input logic z,
                                            input logic ill, input logic rst);
    logic io, mw, iw, rd, m2r, rw, sa, pw, br;
    logic [1:0] sb, ao, ps;
    {io, mw, iw, rd, m2r, rw, sa, pw, br} = '0;
    {sb, ao, ps} = '0;
    case (st)
      4'd0:  begin sb = 2'b01; iw = 1'b1; pw = 1'b1; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  if (addi_on()) begin sa = 1'b1; sb = 2'b10; end
      4'd10: if (addi_on()) rw = 1'b1;
      4'd11: begin ps = 2'b10; pw = 1'b1; end
      default: ;
    endcase
    return {st, io, mw & ~rst, iw & ~rst, rd, m2r, rw & ~rst, sa, sb, ao, ps,
            (pw | (br & z)) & ~rst, ill & ~rst};
  endfunction

  // State sequence an instruction walks through, starting at FETCH.
  task automatic build_seq(input logic [5:0] op, output logic [3:0] seq[$]);
    seq = {4'd0, 4'd1};
    if (op == 6'b100011)                     seq = {seq, 4'd2, 4'd3, 4'd4};
    else if (op == 6'b101011)                seq = {seq, 4'd2, 4'd5};
    else if (op == 6'b000000)                seq = {seq, 4'd6, 4'd7};
    else if (op == 6'b000100)                seq = {seq, 4'd8};
    else if (op == 6'b000010)                seq = {seq, 4'd11};
    else if (op == 6'b001000 && addi_on())   seq = {seq, 4'd9, 4'd10};
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change 1 time unit after the rising edge; the DUT is
  // sampled on the falling edge.
  // ---------------------------------------------------------------------------
  // zmode: 0/1 drive that zero value, 2 randomise zero each cycle.
  task automatic drive_cycle(input string tag, input logic [3:0] st,
                             input logic ill, input int zmode);
    zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    exp_q.push_back(exp_vec(st, zero, ill, reset));
    @(negedge clk);
    check_eq(tag, obs_vec(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int zmode);
    logic [3:0] seq[$];
    opcode = op;
    build_seq(op, seq);
    foreach (seq[i])
      drive_cycle(tag, seq[i], (seq[i] == 4'd1) && !legal_op(op), zmode);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [5:0] op_pool[8];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b111111, 6'b000000};
    reset  = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b1;

    // Reset held for two cycles: write enables must stay low, state = FETCH.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("reset_gate", {14'd0, memWrite, irWrite, regWrite, pcEn, illegalOp}, '0);
      check_eq("reset_state", obs_vec(), exp_vec(4'd0, zero, 1'b0, 1'b1));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed instructions.
    run_instr("lw",        6'b100011, 2);
    run_instr("rtype",     6'b000000, 2);
    run_instr("beq_taken", 6'b000100, 1);
    run_instr("beq_not",   6'b000100, 0);
    run_instr("j",         6'b000010, 2);
    run_instr("illegal",   6'b111111, 2);
    run_instr("addi",      6'b001000, 2);
    run_instr("sw",        6'b101011, 2);

    // Reset arriving in MEMWR of a sw: memWrite dropped that same cycle.
    opcode = 6'b101011;
    drive_cycle("sw_rst", 4'd0, 1'b0, 2);
    drive_cycle("sw_rst", 4'd1, 1'b0, 2);
    drive_cycle("sw_rst", 4'd2, 1'b0, 2);
    reset = 1'b1;
    drive_cycle("sw_rst_memwr", 4'd5, 1'b0, 2);
    reset = 1'b0;
    run_instr("after_rst", 6'b000000, 2);

    // Random instruction mix, including fully random opcodes.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else                           op = op_pool[$urandom_range(0, 7)];
      run_instr("random", op, 2);
    end

    // The last instruction must have retired to FETCH.
    opcode = 6'b000000;
    drive_cycle("final_fetch", 4'd0, 1'b0, 2);

    if (exp_q.size() != 0) $display("FAIL exp_q_drain: got %0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
